// File: rtl/load_store_unit_if.sv
// CPU request/response channel plus word-wide memory port for load_store_unit.
// The slave modport is the unit itself; master is the CPU/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses onto a word-wide memory,
// sub-word stores done as read-modify-write, all outputs registered.
module load_store_unit #(
  parameter bit TRAP_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [2:0]  funct3,
                                            input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] wdata,
                                          input logic [2:0]  funct3,
                                          input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (funct3)
      3'b000: begin
        case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          2'd3:    res[31:24] = wdata[7:0];
          default: res = old_word;
        endcase
      end
      3'b001: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  state_t      r_state, w_next_state;
  logic        r_we, w_nxt_we;
  logic [2:0]  r_funct3, w_nxt_funct3;
  logic [31:0] r_addr, w_nxt_addr;
  logic [31:0] r_wdata, w_nxt_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata, w_nxt_rdata;
  logic        r_resp_error, w_nxt_error;
  logic [31:0] r_mem_address, w_nxt_mem_address;
  logic [31:0] r_mem_write_data, w_nxt_mem_wdata;
  logic        r_mem_write_enable;
  logic        w_illegal;
  logic        w_misaligned;

  // Classify the incoming request (illegal width code, misaligned address)
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (bus.req_we) begin
      w_illegal = (bus.req_funct3 > 3'b010);
    end else begin
      w_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    if (TRAP_MISALIGNED) begin
      case (bus.req_funct3[1:0])
        2'b01:   w_misaligned = bus.req_addr[0];
        2'b10:   w_misaligned = (bus.req_addr[1:0] != 2'b00);
        default: w_misaligned = 1'b0;
      endcase
    end else begin
      w_misaligned = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_next_state      = r_state;
    w_nxt_we          = r_we;
    w_nxt_funct3      = r_funct3;
    w_nxt_addr        = r_addr;
    w_nxt_wdata       = r_wdata;
    w_nxt_rdata       = 32'd0;
    w_nxt_error       = 1'b0;
    w_nxt_mem_address = 32'd0;
    w_nxt_mem_wdata   = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_nxt_we     = bus.req_we;
          w_nxt_funct3 = bus.req_funct3;
          w_nxt_addr   = bus.req_addr;
          w_nxt_wdata  = bus.req_wdata;
          if (w_illegal || w_misaligned) begin
            w_next_state = S_RESP;
            w_nxt_error  = 1'b1;
          end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
            // Full-word store needs no read, so skip straight to the write
            w_next_state      = S_WRITE;
            w_nxt_mem_address = {bus.req_addr[31:2], 2'b00};
            w_nxt_mem_wdata   = bus.req_wdata;
          end else begin
            w_next_state      = S_ACCESS;
            w_nxt_mem_address = {bus.req_addr[31:2], 2'b00};
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_next_state      = S_WRITE;
          w_nxt_mem_address = r_mem_address;
          w_nxt_mem_wdata   = f_merge(bus.mem_read_data, r_wdata, r_funct3, r_addr[1:0]);
        end else begin
          w_next_state = S_RESP;
          w_nxt_rdata  = f_extract(bus.mem_read_data, r_funct3, r_addr[1:0]);
        end
      end
      S_WRITE: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_we               <= 1'b0;
      r_funct3           <= 3'd0;
      r_addr             <= 32'd0;
      r_wdata            <= 32'd0;
      r_req_ready        <= 1'b1;
      r_resp_valid       <= 1'b0;
      r_resp_rdata       <= 32'd0;
      r_resp_error       <= 1'b0;
      r_mem_address      <= 32'd0;
      r_mem_write_data   <= 32'd0;
      r_mem_write_enable <= 1'b0;
    end else begin
      r_state            <= w_next_state;
      r_we               <= w_nxt_we;
      r_funct3           <= w_nxt_funct3;
      r_addr             <= w_nxt_addr;
      r_wdata            <= w_nxt_wdata;
      r_req_ready        <= (w_next_state == S_IDLE);
      r_resp_valid       <= (w_next_state == S_RESP);
      r_resp_rdata       <= w_nxt_rdata;
      r_resp_error       <= w_nxt_error;
      r_mem_address      <= w_nxt_mem_address;
      r_mem_write_data   <= w_nxt_mem_wdata;
      r_mem_write_enable <= (w_next_state == S_WRITE);
    end
  end

  assign bus.req_ready        = r_req_ready;
  assign bus.resp_valid       = r_resp_valid;
  assign bus.resp_rdata       = r_resp_rdata;
  assign bus.resp_error       = r_resp_error;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_write_data   = r_mem_write_data;
  assign bus.mem_write_enable = r_mem_write_enable;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests against a
// word memory model, plus reset-during-write and back-to-back request sequences.
module tb_load_store_unit;

  logic clk;
  logic rst;
  logic [31:0] mem [64];
  int n_checks;
  int n_errors;

  load_store_unit_if bus ();

  load_store_unit #(.TRAP_MISALIGNED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_read_data = mem[bus.mem_address[7:2]];

  // Word memory, written on the rising edge while the strobe is high
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_wr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = valid;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // One request: returns response fields, latency in cycles (0 = none), writes seen
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int wr, output logic [31:0] addr_at_resp);
    @(negedge clk);
    chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
    drive(1'b1, we, f3, addr, wdata);
    @(posedge clk);
    lat = 0; wr = 0; rdata = 32'hA5A5_A5A5; err = 1'bx; addr_at_resp = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_write_enable) wr++;
      if (bus.resp_valid) begin
        lat = k;
        rdata = bus.resp_rdata;
        err = bus.resp_error;
        addr_at_resp = bus.mem_address;
        break;
      end
    end
  endtask

  logic [31:0] g_rdata;
  logic        g_err;
  int          g_lat;
  int          g_wr;
  logic [31:0] g_addr;
  vec_t        cv [6];
  int          acc;
  int          rsp;
  int          stray;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = 32'hDEAD_BEEF;
    mem[30] = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    tbl[0]  = mk(1'b0, 3'b000, 32'h00, 32'h0,         32'hFFFF_FFEF, 1'b0, 2, 0);
    tbl[1]  = mk(1'b0, 3'b100, 32'h00, 32'h0,         32'h0000_00EF, 1'b0, 2, 0);
    tbl[2]  = mk(1'b0, 3'b001, 32'h02, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, 0);
    tbl[3]  = mk(1'b0, 3'b101, 32'h02, 32'h0,         32'h0000_DEAD, 1'b0, 2, 0);
    tbl[4]  = mk(1'b0, 3'b000, 32'h03, 32'h0,         32'hFFFF_FFDE, 1'b0, 2, 0);
    tbl[5]  = mk(1'b0, 3'b100, 32'h01, 32'h0,         32'h0000_00BE, 1'b0, 2, 0);
    tbl[6]  = mk(1'b0, 3'b001, 32'h00, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 0);
    tbl[7]  = mk(1'b0, 3'b010, 32'h00, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0);
    tbl[8]  = mk(1'b1, 3'b010, 32'h50, 32'h1234_5678, 32'h0,         1'b0, 2, 1);
    tbl[9]  = mk(1'b0, 3'b010, 32'h50, 32'h0,         32'h1234_5678, 1'b0, 2, 0);
    tbl[10] = mk(1'b1, 3'b001, 32'h52, 32'hCAFE_BEEF, 32'h0,         1'b0, 3, 1);
    tbl[11] = mk(1'b0, 3'b010, 32'h50, 32'h0,         32'hBEEF_5678, 1'b0, 2, 0);
    tbl[12] = mk(1'b1, 3'b000, 32'h79, 32'h1234_56AA, 32'h0,         1'b0, 3, 1);
    tbl[13] = mk(1'b0, 3'b010, 32'h78, 32'h0,         32'hFFFF_AAFF, 1'b0, 2, 0);
    tbl[14] = mk(1'b1, 3'b000, 32'h7B, 32'h0000_0012, 32'h0,         1'b0, 3, 1);
    tbl[15] = mk(1'b0, 3'b010, 32'h78, 32'h0,         32'h12FF_AAFF, 1'b0, 2, 0);
    tbl[16] = mk(1'b0, 3'b101, 32'h7A, 32'h0,         32'h0000_12FF, 1'b0, 2, 0);
    tbl[17] = mk(1'b0, 3'b000, 32'h7A, 32'h0,         32'hFFFF_FFFF, 1'b0, 2, 0);
    tbl[18] = mk(1'b0, 3'b001, 32'h7A, 32'h0,         32'h0000_12FF, 1'b0, 2, 0);
    tbl[19] = mk(1'b0, 3'b010, 32'h02, 32'h0,         32'h0,         1'b1, 1, 0);
    tbl[20] = mk(1'b1, 3'b001, 32'h01, 32'h0000_1234, 32'h0,         1'b1, 1, 0);
    tbl[21] = mk(1'b0, 3'b011, 32'h00, 32'h0,         32'h0,         1'b1, 1, 0);
    tbl[22] = mk(1'b0, 3'b110, 32'h00, 32'h0,         32'h0,         1'b1, 1, 0);
    tbl[23] = mk(1'b0, 3'b111, 32'h00, 32'h0,         32'h0,         1'b1, 1, 0);
    tbl[24] = mk(1'b1, 3'b011, 32'h00, 32'h1111_1111, 32'h0,         1'b1, 1, 0);
    tbl[25] = mk(1'b1, 3'b100, 32'h50, 32'h2222_2222, 32'h0,         1'b1, 1, 0);
    tbl[26] = mk(1'b1, 3'b010, 32'h52, 32'h3333_3333, 32'h0,         1'b1, 1, 0);
    tbl[27] = mk(1'b0, 3'b001, 32'h03, 32'h0,         32'h0,         1'b1, 1, 0);
    tbl[28] = mk(1'b0, 3'b010, 32'h00, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0);
    tbl[29] = mk(1'b0, 3'b010, 32'h50, 32'h0,         32'hBEEF_5678, 1'b0, 2, 0);
    tbl[30] = mk(1'b0, 3'b100, 32'h03, 32'h0,         32'h0000_00DE, 1'b0, 2, 0);

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'd0, bus.req_ready},        32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid},       32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,                32'd0);
    chk("rst_resp_error", {31'd0, bus.resp_error},       32'd0);
    chk("rst_mem_we",     {31'd0, bus.mem_write_enable}, 32'd0);
    chk("rst_mem_addr",   bus.mem_address,               32'd0);
    chk("rst_mem_wdata",  bus.mem_write_data,            32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_addr",  bus.mem_address,               32'd0);

    for (int i = 0; i < 31; i++) begin
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, g_rdata, g_err, g_lat, g_wr, g_addr);
      chk($sformatf("v%0d_rdata", i),   g_rdata,              tbl[i].exp_rdata);
      chk($sformatf("v%0d_error", i),   {31'd0, g_err},       {31'd0, tbl[i].exp_err});
      chk($sformatf("v%0d_latency", i), g_lat,                tbl[i].exp_lat);
      chk($sformatf("v%0d_writes", i),  g_wr,                 tbl[i].exp_wr);
      chk($sformatf("v%0d_resp_addr", i), g_addr,             32'd0);
    end

    // Reset asserted while an SB is in its WRITE cycle
    mem[30] = 32'hFFFF_FFFF;
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b000, 32'h78, 32'h0000_0055);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rw_access_addr", bus.mem_address, 32'h78);
    chk("rw_access_we",   {31'd0, bus.mem_write_enable}, 32'd0);
    @(negedge clk);
    chk("rw_write_we",    {31'd0, bus.mem_write_enable}, 32'd1);
    chk("rw_write_data",  bus.mem_write_data, 32'hFFFF_FF55);
    #1 rst = 1'b1;
    #1;
    chk("rw_we_drop",     {31'd0, bus.mem_write_enable}, 32'd0);
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_write_enable) stray++;
    end
    rst = 1'b0;
    chk("rw_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_write_enable) stray++;
    end
    chk("rw_no_resp",     stray, 32'd0);
    chk("rw_mem_intact",  mem[30], 32'hFFFF_FFFF);

    // req_valid held high: accepts only in IDLE, one response each, in order
    cv[0] = mk(1'b1, 3'b010, 32'h40, 32'hA5A5_A5A5, 32'h0,         1'b0, 0, 0);
    cv[1] = mk(1'b0, 3'b010, 32'h40, 32'h0,         32'hA5A5_A5A5, 1'b0, 0, 0);
    cv[2] = mk(1'b1, 3'b000, 32'h41, 32'h0000_003C, 32'h0,         1'b0, 0, 0);
    cv[3] = mk(1'b0, 3'b010, 32'h40, 32'h0,         32'hA5A5_3CA5, 1'b0, 0, 0);
    cv[4] = mk(1'b1, 3'b001, 32'h42, 32'h0000_0102, 32'h0,         1'b0, 0, 0);
    cv[5] = mk(1'b0, 3'b101, 32'h42, 32'h0,         32'h0000_0102, 1'b0, 0, 0);
    acc = 0;
    rsp = 0;
    for (int c = 0; c < 80 && rsp < 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (rsp < 6) begin
          chk($sformatf("cont%0d_rdata", rsp), bus.resp_rdata, cv[rsp].exp_rdata);
          chk($sformatf("cont%0d_error", rsp), {31'd0, bus.resp_error}, 32'd0);
        end
        rsp++;
      end
      if (bus.req_ready && acc < 6) begin
        drive(1'b1, cv[acc].we, cv[acc].f3, cv[acc].addr, cv[acc].wdata);
        acc++;
      end else if (acc < 6) begin
        drive(1'b1, 1'b1, 3'b010, 32'h40, 32'hFFFF_FFFF);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid) rsp++;
    end
    chk("cont_accepts",   acc, 32'd6);
    chk("cont_responses", rsp, 32'd6);
    chk("cont_mem_word",  mem[16], 32'h0102_3CA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TRAP_MISALIGNED, default 1: when 1, a misaligned access returns an error and performs no memory access; when 0, the address low bits are ignored for alignment and the access proceeds.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU-side request present.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle pulse marking request completion.
REQ-011 resp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-012 resp_error  output  1  qualified by resp_valid; misaligned access or illegal funct3.
REQ-013 mem_address  output  32  word-aligned byte address to the memory, low 2 bits always 00.
REQ-014 mem_write_data  output  32  full word to be written.
REQ-015 mem_write_enable  output  1  word write strobe; the memory writes on the rising edge.
REQ-016 mem_read_data  input  32  word at mem_address; combinational, valid in the same cycle.

Function
REQ-017 States: IDLE, ACCESS, WRITE, RESP.
REQ-018 IDLE transitions:
- On req_valid && req_ready, all request fields are registered.
- Illegal funct3 (load 011/110/111, store >010) goes to RESP with error.
- Misaligned access (H with addr[0]=1; W with addr[1:0]!=0) goes to RESP with error when TRAP_MISALIGNED=1.
- SW goes to WRITE.
- All other requests go to ACCESS.
REQ-019 ACCESS: mem_address={addr[31:2],2'b00}, mem_write_enable=0, and mem_read_data is captured.
- A load goes to RESP with the extracted data.
- SB/SH goes to WRITE with the merged word.
REQ-020 Load extraction:
- Byte lane is addr[1:0]; halfword lane is addr[1].
- LB/LH sign-extend from bit 7/15.
- LBU/LHU zero-extend.
- LW passes the word through.
REQ-021 Sub-word store merge: only the addressed byte or halfword lane is replaced with req_wdata[7:0]/[15:0]; all other bytes keep the value read in ACCESS.
REQ-022 WRITE: mem_write_enable=1 for exactly one cycle, with mem_address as in ACCESS and mem_write_data = merged word (SW: req_wdata); then go to RESP.
REQ-023 RESP: resp_valid=1 for exactly one cycle; resp_rdata and resp_error are stable in that cycle; then go to IDLE.
REQ-024 Latency from the accepting edge to resp_valid high:
- Load: 2 cycles.
- SW: 2 cycles.
- SB/SH: 3 cycles.
- Error: 1 cycle.
REQ-025 No new request is accepted while busy: req_ready=0 outside IDLE; req inputs are ignored until IDLE.
REQ-026 mem_write_enable is never high outside WRITE; an errored request never writes memory.
REQ-027 In IDLE, RESP and error cases, mem_address=0 and mem_write_data=0.
REQ-028 A back-to-back request presented in the cycle after RESP is accepted on that edge.

Reset
REQ-029 When rst is high, the unit SHALL enter IDLE asynchronously.
- req_ready=1.
- resp_valid=0, resp_rdata=0, resp_error=0.
- mem_write_enable=0, mem_address=0, mem_write_data=0.
REQ-030 Reset asserted mid-operation (ACCESS or WRITE) SHALL abort the request with no response.
- mem_write_enable drops immediately.
- No write occurs on any edge while rst is high.
REQ-031 Registered request fields reset to 0.

Verification
REQ-032 Word 0xDEADBEEF at 0x00; LB 0x00 -> 0xFFFFFFEF; LBU 0x00 -> 0x000000EF; LH 0x02 -> 0xFFFFDEAD; LHU 0x02 -> 0x0000DEAD. Each has resp_valid 2 cycles after acceptance and resp_error=0.
REQ-033 Word 0xFFFFFFFF at 0x78; SB wdata 0x000000AA at 0x79 -> memory word becomes 0xFFFFAAFF; mem_write_enable high for exactly 1 cycle; resp_valid 3 cycles after acceptance.
REQ-034 SW 0x12345678 at 0x50, then LW 0x50 -> resp_rdata 0x12345678; SH 0xBEEF at 0x52 then LW -> 0xBEEF5678.
REQ-035 LW at 0x02 and SH at 0x01 with TRAP_MISALIGNED=1 -> resp_error=1, resp_rdata=0, mem_write_enable stays 0, memory unchanged; load funct3=011 -> resp_error=1.
REQ-036 rst asserted during WRITE of an SB to 0x78 -> mem_write_enable=0 in the same cycle, word stays 0xFFFFFFFF, no resp_valid, req_ready=1 after reset.
REQ-037 req_valid held high continuously with alternating loads and stores -> each request is accepted only in IDLE, exactly one resp_valid per accepted request, in order.
